// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator car controller and its display.
package elevator_pkg;

   localparam int FLOOR_W = 4;
   localparam int CNT_W   = 4;

   localparam logic [FLOOR_W-1:0] RESET_FLOOR = 4'd1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MOVING = 2'd1,
      ST_DOOR   = 2'd2
   } state_t;

endpackage

// File: rtl/elevator_scheduler_if.sv
// Call-button / display side bus of the elevator controller.
interface elevator_scheduler_if #(
   parameter int NUM_FLOORS = 8
) ();
   import elevator_pkg::*;

   logic                  tick;
   logic [NUM_FLOORS-1:0] req;
   logic [FLOOR_W-1:0]    floor;
   logic [CNT_W-1:0]      countdown;
   logic [NUM_FLOORS-1:0] pending;
   logic                  dir_up;
   logic                  moving;
   logic                  door_open;

   // Stimulus side: drives tick and call buttons, observes car status.
   modport master (
      output tick, req,
      input  floor, countdown, pending, dir_up, moving, door_open
   );

   // Controller side.
   modport slave (
      input  tick, req,
      output floor, countdown, pending, dir_up, moving, door_open
   );
endinterface

// File: rtl/floor_request_scan.sv
// Splits the pending request vector into here / above / below the car.
module floor_request_scan
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = 8
) (
   input  logic [NUM_FLOORS-1:0] pending,
   input  logic [FLOOR_W-1:0]    floor,
   output logic                  here,
   output logic                  above,
   output logic                  below
);

   // Bit i stands for floor i+1; compare each against the car position.
   always_comb begin
      here  = 1'b0;
      above = 1'b0;
      below = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (i + 1 == int'(floor))     here  = here  | pending[i];
         else if (i + 1 > int'(floor)) above = above | pending[i];
         else                          below = below | pending[i];
      end
   end

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN elevator car controller: latches calls, steps the car, times the door.
module elevator_scheduler
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = 8,
   parameter int MOVE_TICKS = 2,
   parameter int DOOR_TIME  = 5
) (
   input  logic                 CLK,
   input  logic                 rst,
   elevator_scheduler_if.slave  bus
);

   localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS);
   localparam logic [CNT_W-1:0]   MOVE_LD   = CNT_W'(MOVE_TICKS);
   localparam logic [CNT_W-1:0]   DOOR_LD   = CNT_W'(DOOR_TIME);

   state_t                state_q, state_d;
   logic [FLOOR_W-1:0]    floor_q, floor_d;
   logic [CNT_W-1:0]      cd_q, cd_d;
   logic [CNT_W-1:0]      move_cnt_q, move_cnt_d;
   logic [NUM_FLOORS-1:0] pending_q, pending_d;
   logic                  dir_q, dir_d;

   logic                  here, above, below;
   logic [NUM_FLOORS-1:0] cur_mask, nxt_mask, clr, latch;
   logic [FLOOR_W-1:0]    step_floor;
   logic                  reload, step_ok;

   floor_request_scan #(.NUM_FLOORS(NUM_FLOORS)) u_scan (
      .pending (pending_q),
      .floor   (floor_q),
      .here    (here),
      .above   (above),
      .below   (below)
   );

   // One-hot masks for the current floor and the floor the car would step to.
   always_comb begin
      step_floor = dir_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
      step_ok    = dir_q ? (floor_q < TOP_FLOOR) : (floor_q > RESET_FLOOR);
      cur_mask   = NUM_FLOORS'(1) << (floor_q - FLOOR_W'(1));
      nxt_mask   = NUM_FLOORS'(1) << (step_floor - FLOOR_W'(1));
   end

   // Next-state logic: request latch, door extension and tick-driven SCAN steps.
   always_comb begin
      state_d    = state_q;
      floor_d    = floor_q;
      cd_d       = cd_q;
      move_cnt_d = move_cnt_q;
      dir_d      = dir_q;
      clr        = '0;

      // A call for the floor whose door is open extends the dwell instead of latching.
      reload = (state_q == ST_DOOR) && ((bus.req & cur_mask) != '0);
      latch  = (state_q == ST_DOOR) ? (bus.req & ~cur_mask) : bus.req;

      if (bus.tick) begin
         unique case (state_q)
            ST_IDLE: begin
               if (here) begin
                  state_d = ST_DOOR;
                  cd_d    = DOOR_LD;
                  clr     = cur_mask;
               end else if ((dir_q && above) || (!dir_q && below)) begin
                  state_d    = ST_MOVING;
                  move_cnt_d = MOVE_LD;
               end else if (above || below) begin
                  dir_d      = above;
                  state_d    = ST_MOVING;
                  move_cnt_d = MOVE_LD;
               end
            end
            ST_MOVING: begin
               if (move_cnt_q == CNT_W'(1)) begin
                  // Arrival and the stop decision happen on the same tick.
                  if (step_ok) floor_d = step_floor;
                  if (step_ok && (pending_q & nxt_mask) != '0) begin
                     state_d    = ST_DOOR;
                     cd_d       = DOOR_LD;
                     clr        = nxt_mask;
                     move_cnt_d = '0;
                  end else begin
                     move_cnt_d = MOVE_LD;
                  end
               end else begin
                  move_cnt_d = move_cnt_q - CNT_W'(1);
               end
            end
            ST_DOOR: begin
               if (cd_q == CNT_W'(1)) begin
                  cd_d    = '0;
                  state_d = ST_IDLE;
               end else begin
                  cd_d = cd_q - CNT_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // Reload beats the decrement and keeps the door open.
      if (reload) begin
         cd_d    = DOOR_LD;
         state_d = ST_DOOR;
      end

      // Clearing on door entry wins over a same-cycle call for that floor.
      pending_d = (pending_q | latch) & ~clr;
   end

   // Registered state, counters, floor and pending latch.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         floor_q    <= RESET_FLOOR;
         cd_q       <= '0;
         move_cnt_q <= '0;
         pending_q  <= '0;
         dir_q      <= 1'b1;
      end else begin
         state_q    <= state_d;
         floor_q    <= floor_d;
         cd_q       <= cd_d;
         move_cnt_q <= move_cnt_d;
         pending_q  <= pending_d;
         dir_q      <= dir_d;
      end
   end

   assign bus.floor     = floor_q;
   assign bus.countdown = cd_q;
   assign bus.pending   = pending_q;
   assign bus.dir_up    = dir_q;
   assign bus.moving    = (state_q == ST_MOVING);
   assign bus.door_open = (state_q == ST_DOOR);

   // The car must never be asked to step past either end of the shaft.
   a_no_overrun: assert property (@(posedge CLK) disable iff (rst)
      (bus.tick && state_q == ST_MOVING && move_cnt_q == CNT_W'(1)) |-> step_ok);

   a_floor_range: assert property (@(posedge CLK) disable iff (rst)
      (floor_q >= RESET_FLOOR && floor_q <= TOP_FLOOR));

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Elevator car controller that latches floor call requests, chooses travel direction with a SCAN (collective) policy, steps the car floor by floor and times the door-open interval. It sits between the call-button/LED layer and the `Display` block. Its `floor` and `countdown` outputs drive `Display` directly. All sequencing advances on `tick`, a one-cycle enable from `ClockDivider`.

## Interface
Parameters:
- `NUM_FLOORS`, default 8: floors numbered 1..NUM_FLOORS; legal range 2..15.
- `MOVE_TICKS`, default 2: ticks per floor of travel; legal range 1..15.
- `DOOR_TIME`, default 5: door-open ticks; legal range 1..15.

Ports:
- `CLK`, in, 1: the single clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `tick`, in, 1: step enable, one `CLK` cycle wide.
- `req`, in, NUM_FLOORS: call requests; bit i means floor i+1; sampled every `CLK` edge.
- `floor`, out, 4: current floor, 1..NUM_FLOORS.
- `countdown`, out, 4: remaining door ticks; 0 when the door is closed.
- `pending`, out, NUM_FLOORS: latched, unserved requests (LED drive).
- `dir_up`, out, 1: current SCAN direction; 1 means up.
- `moving`, out, 1: high in MOVING.
- `door_open`, out, 1: high in DOOR.

## Operation
- States: IDLE, MOVING, DOOR. Outputs are registered.
- Reset values: state IDLE, `floor`=1, `countdown`=0, `pending`=0, `dir_up`=1, internal `move_cnt`=0.
- Derived terms, from `pending`:
  - `here` = bit for the current floor.
  - `above` = any bit for floors above the current floor.
  - `below` = any bit for floors below the current floor.
- Request latch, every `CLK` edge: `pending |= req`, with two exceptions:
  - A req for the current floor while in DOOR is not latched. It reloads `countdown`=DOOR_TIME instead.
  - When a bit is cleared on DOOR entry in the same cycle as a req for that floor, the clear wins.
- IDLE, on tick:
  - If `here`: go to DOOR, set `countdown`=DOOR_TIME, clear `here`.
  - Else if (`dir_up` & `above`) or (~`dir_up` & `below`): go to MOVING with `move_cnt`=MOVE_TICKS, keep direction.
  - Else if `above` or `below`: flip `dir_up` toward the pending side, go to MOVING with `move_cnt`=MOVE_TICKS.
  - Else: stay in IDLE.
- MOVING, on tick: `move_cnt` -= 1. When it reaches 0, `floor` moves ±1 per `dir_up`. The decision is taken on the new floor in the same tick:
  - If that floor's bit is set: go to DOOR, set `countdown`=DOOR_TIME, clear the bit.
  - Else: reload `move_cnt`=MOVE_TICKS and continue.
- Travel limits:
  - A request ahead of the car always exists while MOVING, because bits clear only on DOOR entry.
  - `floor` never leaves 1..NUM_FLOORS. An implementation that would step past an end is a bug; flag it with an assertion.
- DOOR, on tick: `countdown` -= 1. On reaching 0, go to IDLE; the direction decision is made on the following tick.
- A `countdown` reload on a same-floor req overrides the decrement in that cycle.
- `moving` and `door_open` decode the state. `countdown` is 0 outside DOOR.
- When `tick` is low, only the request latch and the DOOR reload act.

## Timing
- A req is visible on `pending` 1 `CLK` cycle after it is sampled.
- IDLE→MOVING takes 1 tick. The first floor change comes MOVE_TICKS ticks after entering MOVING. Each further floor takes MOVE_TICKS ticks.
- Arrival and DOOR entry happen in the same tick.
- Door dwell: DOOR_TIME ticks, then IDLE. Next departure is ≥1 tick later.
- `rst` clears all state immediately, including mid-travel and mid-door. There is no recovery of `pending`.
- `tick` is asserted for one cycle only. Behaviour when `tick` is held high is defined as one step per `CLK`.

## Structure
- `elevator_pkg` holds:
  - the state encodings IDLE, MOVING, DOOR;
  - width constants `FLOOR_W`=4 and `CNT_W`=4;
  - the reset floor constant (1).
- Shared with `Display` and the top level.
- One sub-module, `floor_request_scan`: purely combinational. It takes `pending` and `floor` and returns `here`, `above` and `below`.
- Single always block for state, counters, floor and the pending latch.

## Test plan
Test parameters: NUM_FLOORS=8, MOVE_TICKS=2, DOOR_TIME=5. "tick N" counts from the first tick after the stimulus.
1. Reset → `floor`=1, `countdown`=0, `pending`=0, `dir_up`=1, `moving`=0, `door_open`=0.
2. At floor 1 in IDLE, pulse `req`=8'b0000_1000 →
   - `pending`=8'h08; tick 1: MOVING;
   - `floor`=2 at tick 3, 3 at tick 5, 4 at tick 7, with DOOR, `countdown`=5 and `pending`=0 at tick 7;
   - `countdown` 4,3,2,1,0 on ticks 8–12, then IDLE.
3. SCAN ordering: car moving up, just past floor 3, with requests for floors 2 and 6 → car stops at 6 first. It then reverses (`dir_up`=0 at the IDLE tick) and stops at 2. `pending`=0 at the end.
4. Door extension: in DOOR at floor 4 with `countdown`=2, pulse req bit 3 → `countdown`=5, bit 3 of `pending` stays 0.
5. At floor 1 in IDLE, pulse req bit 0 → next tick: DOOR, `countdown`=5, `floor` stays 1, `moving` never asserts.
6. Reset mid-travel: assert `rst` at `floor`=3 while MOVING, with `pending`=8'h80 → same cycle: `floor`=1, `pending`=0, IDLE. After release, no motion without a new req.
